// File: rtl/cluster_wake_bridge_if.sv
// TCDM-style request/response bundle shared by the SoC-side port and the
// cluster-side port of the wake bridge.
interface cluster_wake_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   add;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ID_WIDTH-1:0]     id;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [ID_WIDTH-1:0]     r_id;

  modport master (
    output req, add, wen, wdata, be, id,
    input  gnt, r_valid, r_rdata, r_id
  );

  modport slave (
    input  req, add, wen, wdata, be, id,
    output gnt, r_valid, r_rdata, r_id
  );
endinterface

// File: rtl/cluster_wake_bridge.sv
// One-entry request buffer in front of a clock-gated cluster: holds the wake
// request while busy, forwards only when un-isolated, and counts outstanding ops.
module cluster_wake_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cluster_wake_bridge_if.slave  up,
  cluster_wake_bridge_if.master dn,
  input  logic                  isolate_i,
  output logic                  wake_req_o,
  output logic                  err_o
);
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, WAKE, FWD} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   add;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ID_WIDTH-1:0]     id;
  } payload_t;

  state_e                state_q, state_d;
  payload_t              buf_q, buf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic                  gnt_c, req_c, err_c, handshake, cnt_dec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Isolation seen in FWD is a gate protocol violation: fall back to WAKE
  // and retry the retained request once the cluster is reachable again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (up.req) state_d = isolate_i ? WAKE : FWD;
      WAKE:    if (!isolate_i) state_d = FWD;
      FWD: begin
        if (isolate_i)      state_d = WAKE;
        else if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_c     = up.req && (state_q == IDLE);
    req_c     = (state_q == FWD) && !isolate_i && (cnt_q < CNT_MAX);
    err_c     = (state_q == FWD) && isolate_i;
    handshake = req_c && dn.gnt;
  end

  // Responses with nothing outstanding are forwarded but never counted, so a
  // stray response after reset cannot underflow the counter.
  always_comb begin
    buf_d = buf_q;
    if (gnt_c) begin
      buf_d = '{add: up.add, wen: up.wen, wdata: up.wdata, be: up.be, id: up.id};
    end
    cnt_dec = dn.r_valid && (cnt_q != '0);
    cnt_d   = cnt_q;
    if (handshake && !cnt_dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (!handshake && cnt_dec) cnt_d = cnt_q - CNT_W'(1);
    r_valid_d = dn.r_valid;
    r_rdata_d = dn.r_rdata;
    r_id_d    = dn.r_id;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_id_q    <= '0;
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_id_q    <= r_id_d;
    end
  end

  assign up.gnt     = gnt_c;
  assign up.r_valid = r_valid_q;
  assign up.r_rdata = r_rdata_q;
  assign up.r_id    = r_id_q;

  assign dn.req   = req_c;
  assign dn.add   = buf_q.add;
  assign dn.wen   = buf_q.wen;
  assign dn.wdata = buf_q.wdata;
  assign dn.be    = buf_q.be;
  assign dn.id    = buf_q.id;

  // Combinational so the clock gate sees a fresh upstream request in its own cycle.
  assign wake_req_o = up.req || (state_q != IDLE) || (cnt_q != '0);
  assign err_o      = err_c;
endmodule
